// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type, default frame constants
// and a helper that derives the oversample clock divider from clock/baud.
package uart_pkg;

  localparam int UART_OSR       = 16;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Rounded clk cycles per oversample tick for a given clock and baud rate.
  function automatic int calc_clk_div(input int unsigned clk_hz,
                                      input int unsigned baud,
                                      input int unsigned osr);
    int unsigned ticks_hz;
    ticks_hz = baud * osr;
    return int'((clk_hz + ticks_hz / 2) / ticks_hz);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..CLK_DIV-1 and pulses tick_o on the
// wrap cycle. clr_i restarts the count so the tick phase can be aligned to
// an external event (the RX start edge). Shared with the TX side.
module uart_baud_tick #(
  parameter int CLK_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  // Next count: wrap on tick, restart on clear.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d (no latch).
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  // Divider counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: synchronises the serial line, oversamples at OSR x baud,
// recovers LSB-first frames and hands bytes out through a one-entry holding
// register with valid/ready. Reports framing errors and sticky overrun.
// Optional parity check is built when UART_RX_PARITY_EN is defined.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 54,
  parameter int OSR       = UART_OSR,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  input  logic                 overrun_clr_i,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd_i,
`endif
  output logic                 busy_o
);

  localparam int OSW = $clog2(OSR);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [OSW-1:0] OS_MID   = OSW'(OSR / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OSR - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  logic                 fall, tick, tick_clr, hold_free;
  rx_state_t            state_q;
  logic [OSW-1:0]       os_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, parity_err_q, par_bad;
`endif

  // Two-flop synchroniser plus one history flop for edge detection; all
  // preset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes the previous stage's old value.
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall      = prev_q & ~sync2_q;
  assign tick_clr  = fall & (state_q == RX_IDLE);
  assign shift_d   = {sync2_q, shift_q[DATA_BITS-1:1]};
  assign hold_free = ~rx_valid_q | rx_ready_i;
`ifdef UART_RX_PARITY_EN
  assign par_bad   = ((^shift_q) ^ par_bit_q) != parity_odd_i;
`endif

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Frame FSM with registered handoff, error and overrun outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Acceptance empties the holder; a same-edge load below overrides.
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;

      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            os_cnt_q <= '0;
            state_q  <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (os_cnt_q == OS_MID) begin
              if (sync2_q) begin
                state_q <= RX_IDLE;
              end else begin
                os_cnt_q  <= '0;
                bit_cnt_q <= '0;
                state_q   <= RX_DATA;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q  <= '0;
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= RX_PARITY;
`else
                state_q <= RX_STOP;
`endif
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q  <= '0;
              par_bit_q <= sync2_q;
              state_q   <= RX_STOP;
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q <= '0;
              state_q  <= RX_IDLE;
              if (!sync2_q) begin
                frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad) begin
                parity_err_q <= 1'b1;
`endif
              end else if (hold_free) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase

      // Clear is last so it wins over a same-cycle overrun set.
      if (overrun_clr_i) overrun_q <= 1'b0;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with CLK_DIV=4, OSR=16 (64 clk per bit).
// Define UART_RX_PARITY_EN to also exercise the parity frame format.
module tb_uart_rx_core;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR  = 1'b1;
  // Start edge -> valid: 3 sync/edge clks + 168 ticks * 4 clks.
  localparam int LATENCY  = 675;
`else
  localparam bit HAS_PAR  = 1'b0;
  // Start edge -> valid: 3 sync/edge clks + 152 ticks * 4 clks.
  localparam int LATENCY  = 611;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;
  logic       overrun_clr_i;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd_i;
`endif

  int compared   = 0;
  int mismatched = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = '0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  logic       valid_prev = 1'b0;
  int         r0, f0, p0;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_DIV(4), .OSR(16), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (rx_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .frame_err_o   (frame_err_o),
    .parity_err_o  (parity_err_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i  (parity_odd_i),
`endif
    .busy_o        (busy_o)
  );

  // Posedge counter used to time the receive latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: valid rises, and error pulse widths counted in cycles.
  always @(negedge clk) begin
    valid_prev <= rx_valid_o;
    if (rx_valid_o && !valid_prev) begin
      rise_cnt  <= rise_cnt + 1;
      rise_cyc  <= cyc;
      rise_data <= rx_data_o;
    end
    if (frame_err_o)  ferr_cnt <= ferr_cnt + 1;
    if (parity_err_o) perr_cnt <= perr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame LSB first; call on a negedge. Ends after a short idle gap.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    start_cyc = cyc;
    rx_i = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (HAS_PAR) begin
      rx_i = par_b;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_i = stop_b;
    repeat (BIT_CLKS) @(negedge clk);
    rx_i = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx_i = 1'b1;
    rx_ready_i = 1'b1;
    overrun_clr_i = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_odd_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_valid", rx_valid_o, 0);
    check("reset_data", rx_data_o, 0);
    check("reset_ferr", frame_err_o, 0);
    check("reset_perr", parity_err_o, 0);
    check("reset_ovr", overrun_o, 0);
    check("reset_busy", busy_o, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // 1: clean 0xA5
    r0 = rise_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    check("a5_rise", rise_cnt - r0, 1);
    check("a5_data", rise_data, 8'hA5);
    check("a5_latency", rise_cyc - start_cyc, LATENCY);
    check("a5_ferr", ferr_cnt - f0, 0);
    check("a5_perr", perr_cnt - p0, 0);
    check("a5_busy", busy_o, 0);
    check("a5_valid_taken", rx_valid_o, 0);

    // 2: 3-tick low glitch
    r0 = rise_cnt; f0 = ferr_cnt;
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy", busy_o, 1);
    repeat (7) @(negedge clk);
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_idle", busy_o, 0);
    check("glitch_rise", rise_cnt - r0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // 3: 0x3C with bad stop, then 0x81
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_rise", rise_cnt - r0, 0);
    check("ferr_busy", busy_o, 0);
    send_frame(8'h81, 1'b1, ^8'h81);
    check("after_ferr_rise", rise_cnt - r0, 1);
    check("after_ferr_data", rise_data, 8'h81);
    check("after_ferr_ferr", ferr_cnt - f0, 1);

    // 4: overrun with consumer stalled
    r0 = rise_cnt;
    rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11);
    check("ovr_first_valid", rx_valid_o, 1);
    check("ovr_first_data", rx_data_o, 8'h11);
    check("ovr_first_flag", overrun_o, 0);
    send_frame(8'h22, 1'b1, ^8'h22);
    check("ovr_hold_data", rx_data_o, 8'h11);
    check("ovr_hold_valid", rx_valid_o, 1);
    check("ovr_flag", overrun_o, 1);
    check("ovr_rise", rise_cnt - r0, 1);
    overrun_clr_i = 1'b1;
    @(negedge clk);
    overrun_clr_i = 1'b0;
    check("ovr_cleared", overrun_o, 0);
    rx_ready_i = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", rx_valid_o, 0);

    // 5: reset in the middle of 0xFF data bits
    r0 = rise_cnt; f0 = ferr_cnt;
    rx_i = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx_i = 1'b1;
    repeat (BIT_CLKS * 3 + 32) @(negedge clk);
    check("mid_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_valid", rx_valid_o, 0);
    check("rst_data", rx_data_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (BIT_CLKS * 8) @(negedge clk);
    check("post_rst_rise", rise_cnt - r0, 0);
    check("post_rst_ferr", ferr_cnt - f0, 0);
    send_frame(8'h55, 1'b1, ^8'h55);
    check("post_rst_55_rise", rise_cnt - r0, 1);
    check("post_rst_55_data", rise_data, 8'h55);

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 0x07
    r0 = rise_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok_rise", rise_cnt - r0, 1);
    check("par_ok_data", rise_data, 8'h07);
    check("par_ok_perr", perr_cnt - p0, 0);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_rise", rise_cnt - r0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive front end feeding the UART top's RX data register and RX interrupt logic.
- Takes the asynchronous serial line.
- Oversamples it at OSR× the baud rate and recovers 8N1 frames, LSB first.
- Presents each byte through a valid/ready handshake with a one-entry holding register.
- Flags framing and overrun errors. The downstream RX read (rx_data_read_en path) drives rx_ready_i.

Parameters:
CLK_DIV, 54, clk cycles per oversample tick (100 MHz / (115200×16) ≈ 54); must be ≥2
OSR, 16, oversample ticks per bit; must be even and ≥4
DATA_BITS, 8, data bits per frame (5..8)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous, active-high reset
rx_i  in  1  serial line, idle high, asynchronous to clk
rx_data_o  out  DATA_BITS  received byte, stable while rx_valid_o=1
rx_valid_o  out  1  holding register full
rx_ready_i  in  1  consumer accepts rx_data_o when rx_valid_o&rx_ready_i
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
parity_err_o  out  1  one-cycle pulse: parity mismatch (always 0 without macro)
overrun_o  out  1  sticky: completed byte dropped because holding register full
overrun_clr_i  in  1  clears overrun_o (clear wins over a same-cycle set)
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; rx_data_o = 0.
  - FSM = IDLE.
  - Synchroniser flops preset to 1 (line idle).
- rx_i passes through a 2-flop synchroniser. A falling edge is detected as previous synced = 1 and current synced = 0.
- Tick generator:
  - Counter 0..CLK_DIV-1; a tick pulses when it wraps.
  - Counter is forced to 0 on a falling edge detected in IDLE, so phase aligns to the start edge.
- Oversample counter os_cnt runs 0..OSR-1 and advances on ticks only.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: on falling edge, clear os_cnt and go to START.
  - START:
    - At os_cnt = OSR/2-1, sample the line.
    - If high (glitch), go to IDLE with no output.
    - Else clear os_cnt and bit_cnt, go to DATA.
  - DATA:
    - Each time os_cnt wraps at OSR-1 (mid-bit), shift the sample in LSB-first.
    - After DATA_BITS samples, go to STOP (or PARITY with the macro).
  - STOP:
    - At os_cnt wrap, sample the line.
    - If 1, the frame completes. If 0, pulse frame_err_o and discard the byte.
    - Either way go to IDLE. A new frame needs a fresh falling edge, so a held-low break does not retrigger.
- Handoff: on frame completion, the holding register is free if rx_valid_o = 0, or if rx_valid_o & rx_ready_i in the same cycle.
  - If free: load rx_data_o and set rx_valid_o on the next clk edge. Latency is 1 clk after the stop-sample tick.
  - If not free: keep the old byte, set overrun_o, drop the new byte.
- rx_valid_o drops on the clk after acceptance unless a new byte loads that same edge.
- While rx_valid_o = 1, rx_data_o is not altered.
- rx_ready_i while rx_valid_o = 0 is ignored.
- Reset mid-frame abandons the frame immediately. No partial byte or error pulse is produced.
- busy_o = 1 in every state except IDLE.

Optional Feature:
UART_RX_PARITY_EN:
- Adds a PARITY state between DATA and STOP and an input parity_odd_i (1 = odd parity, 0 = even).
- The parity bit is sampled at mid-bit.
- On mismatch, parity_err_o pulses for one cycle coincident with completion, and the byte is discarded.
- Frame error takes priority: if both occur, only frame_err_o pulses.
- Without the macro: no PARITY state, no parity_odd_i port, parity_err_o tied 0.

Decomposition:
- Package uart_pkg:
  - FSM state enum (rx_state_t).
  - Default constants UART_OSR = 16, UART_DATA_BITS = 8.
  - Function for CLK_DIV from clock and baud rate.
- One sub-module, uart_baud_tick: CLK_DIV divider with sync clear input and tick output. It is reusable by the TX side.

Test Plan:
All scenarios use CLK_DIV=4, OSR=16, rx_ready_i=1 unless noted.
1. Send 0xA5 (8N1) → rx_valid_o rises 1 clk after the stop sample, rx_data_o = 0xA5, no error pulses, busy_o low afterwards.
2. Low glitch on rx_i of 3 ticks → returns to IDLE, rx_valid_o stays 0, no errors.
3. Send 0x3C with stop bit = 0 → frame_err_o single-cycle pulse, rx_valid_o stays 0; a following 0x81 is received correctly.
4. rx_ready_i = 0, send 0x11 then 0x22 → rx_data_o holds 0x11, overrun_o = 1 after the second stop. Pulse overrun_clr_i → 0. Assert ready → valid drops.
5. Assert rst in the middle of the DATA bits of 0xFF → all outputs 0 immediately. After release, 0x55 is received correctly.
6. With UART_RX_PARITY_EN and parity_odd_i = 0: send 0x07 with parity bit 1 → accepted; with parity bit 0 → parity_err_o pulse, no valid.
